// File: rtl/fft4_frame_sequencer_if.sv
// Bus bundle for the 4-point FFT frame sequencer: sample stream in, FFT
// launch/result bus, bin stream out and status. Suffixes are seen from the
// sequencer's side (_i driven into it, _o driven by it).
interface fft4_frame_sequencer_if #(
  parameter int SAMPLE_SIZE      = 16,
  parameter int CALCULATION_SIZE = 24
);
  logic [SAMPLE_SIZE-1:0]        sample_in_i;
  logic                          sample_valid_i;
  logic                          sample_ready_o;
  logic [4*SAMPLE_SIZE-1:0]      fft_input_real_o;
  logic                          fft_read_o;
  logic                          fft_done_i;
  logic [4*CALCULATION_SIZE-1:0] fft_output_real_i;
  logic [4*CALCULATION_SIZE-1:0] fft_output_imag_i;
  logic [CALCULATION_SIZE-1:0]   bin_real_o;
  logic [CALCULATION_SIZE-1:0]   bin_imag_o;
  logic [1:0]                    bin_index_o;
  logic                          bin_last_o;
  logic                          bin_valid_o;
  logic                          bin_ready_i;
  logic                          busy_o;
  logic                          timeout_error_o;

  modport slave (
    input  sample_in_i, sample_valid_i, fft_done_i, fft_output_real_i,
           fft_output_imag_i, bin_ready_i,
    output sample_ready_o, fft_input_real_o, fft_read_o, bin_real_o,
           bin_imag_o, bin_index_o, bin_last_o, bin_valid_o, busy_o,
           timeout_error_o
  );

  modport master (
    output sample_in_i, sample_valid_i, fft_done_i, fft_output_real_i,
           fft_output_imag_i, bin_ready_i,
    input  sample_ready_o, fft_input_real_o, fft_read_o, bin_real_o,
           bin_imag_o, bin_index_o, bin_last_o, bin_valid_o, busy_o,
           timeout_error_o
  );
endinterface

// File: rtl/fft4_frame_sequencer.sv
// Packs streaming samples into 4-sample frames, launches one FFT per frame,
// waits (with timeout) for the result and streams the 4 bins out.
// A one-frame collector keeps taking samples while the FFT is occupied.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no FFT job; a completed (or pending) frame launches at once
// START | fft_read strobe, frame presented on fft_input_real
// BUSY  | waiting for fft_done, timeout down-counter running
// DRAIN | bins 0..3 presented with valid/ready from the result register
module fft4_frame_sequencer #(
  parameter int SAMPLE_SIZE      = 16,
  parameter int CALCULATION_SIZE = 24,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input logic                   clock_i,
  input logic                   reset_i,
  fft4_frame_sequencer_if.slave bus
);
  localparam int SW = SAMPLE_SIZE;
  localparam int CW = CALCULATION_SIZE;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, START, BUSY, DRAIN} state_t;

  state_t          state_q;
  logic [SW-1:0]   slot_q [4];
  logic [2:0]      count_q;
  logic            pending_q;
  logic [4*SW-1:0] frame_q;
  logic [TW-1:0]   timer_q;
  logic [4*CW-1:0] res_real_q;
  logic [4*CW-1:0] res_imag_q;
  logic [1:0]      idx_q;
  logic            fft_read_q;
  logic            bin_valid_q;
  logic            timeout_q;

  logic            accept;
  logic            frame_done;
  logic            drain_end;
  logic            engine_free;
  logic            launch_new;
  logic            launch_pend;
  logic            launch;
  logic [4*SW-1:0] frame_d;

  // A full collector (pending) stalls the source; otherwise every valid is taken.
  assign accept      = bus.sample_valid_i && !pending_q;
  assign frame_done  = accept && (count_q == 3'd3);
  assign drain_end   = (state_q == DRAIN) && bus.bin_ready_i && (idx_q == 2'd3);
  assign engine_free = (state_q == IDLE) || drain_end;
  assign launch_new  = frame_done && engine_free;
  assign launch_pend = pending_q && engine_free;
  assign launch      = launch_new || launch_pend;
  // A frame completing this cycle has its last sample still on the input bus.
  assign frame_d     = launch_pend ? {slot_q[3], slot_q[2], slot_q[1], slot_q[0]}
                                   : {bus.sample_in_i, slot_q[2], slot_q[1], slot_q[0]};

  // Collector: fill slots in arrival order, hand frames over or hold one pending.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int k = 0; k < 4; k++) slot_q[k] <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      if (accept) slot_q[count_q[1:0]] <= bus.sample_in_i;
      if (launch) begin
        frame_q   <= frame_d;
        count_q   <= '0;
        pending_q <= 1'b0;
      end else if (accept) begin
        count_q <= count_q + 3'd1;
        if (frame_done) pending_q <= 1'b1;
      end
    end
  end

  // Sequencer FSM: launch, wait with timeout, capture results, drain bins.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      res_real_q  <= '0;
      res_imag_q  <= '0;
      idx_q       <= '0;
      fft_read_q  <= 1'b0;
      bin_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q    <= START;
            fft_read_q <= 1'b1;
          end
        end
        START: begin
          fft_read_q <= 1'b0;
          timer_q    <= TW'(TIMEOUT_CYCLES - 1);
          state_q    <= BUSY;
        end
        BUSY: begin
          if (bus.fft_done_i) begin
            res_real_q  <= bus.fft_output_real_i;
            res_imag_q  <= bus.fft_output_imag_i;
            idx_q       <= '0;
            bin_valid_q <= 1'b1;
            state_q     <= DRAIN;
          end else if (timer_q == '0) begin
            // Frame is dropped; a pending frame relaunches through IDLE.
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        DRAIN: begin
          if (bus.bin_ready_i) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              bin_valid_q <= 1'b0;
              if (launch) begin
                state_q    <= START;
                fft_read_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sample_ready_o   = !pending_q;
  assign bus.fft_input_real_o = frame_q;
  assign bus.fft_read_o       = fft_read_q;
  // Bins are passed through bit-exact from the captured result buses.
  assign bus.bin_real_o       = res_real_q[int'(idx_q)*CW +: CW];
  assign bus.bin_imag_o       = res_imag_q[int'(idx_q)*CW +: CW];
  assign bus.bin_index_o      = idx_q;
  assign bus.bin_last_o       = bin_valid_q && (idx_q == 2'd3);
  assign bus.bin_valid_o      = bin_valid_q;
  assign bus.busy_o           = (state_q != IDLE);
  assign bus.timeout_error_o  = timeout_q;
endmodule

// File: tb/tb_fft4_frame_sequencer.sv
// Bench for fft4_frame_sequencer: queue-based reference model of the
// collector / FFT job / bin stream, an FFT stub with programmable latency,
// directed scenarios with literal expectations and a randomized soak.
module tb_fft4_frame_sequencer;
  localparam int SW = 16;
  localparam int CW = 24;
  localparam int T  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft4_frame_sequencer_if #(.SAMPLE_SIZE(SW), .CALCULATION_SIZE(CW)) bus();

  fft4_frame_sequencer #(.SAMPLE_SIZE(SW), .CALCULATION_SIZE(CW), .TIMEOUT_CYCLES(T)) dut (
    .clock_i(clk),
    .reset_i(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  logic [SW-1:0]   m_held[$];
  logic [4*SW-1:0] m_frame;
  logic [CW-1:0]   m_bre[$];
  logic [CW-1:0]   m_bim[$];
  bit              m_read, m_wait, m_tmo;
  int              m_wcnt, m_acc;

  // FFT stub state
  int stub_lat, stub_cnt, fire_cyc, n_reads;
  bit stub_arm, stub_fixed, spur_en;
  logic [CW-1:0] fx_re [4];
  logic [CW-1:0] fx_im [4];

  bit ready_drop_seen;
  int acc_at_drop;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(string name);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d wait bound expired", name, cyc);
  endtask

  function automatic bit exp_busy();
    return m_read || m_wait || (m_bre.size() != 0);
  endfunction

  task automatic model_reset();
    m_held.delete(); m_bre.delete(); m_bim.delete();
    m_frame = '0; m_read = 0; m_wait = 0; m_tmo = 0; m_wcnt = 0;
    stub_cnt = 0; stub_arm = 0;
  endtask

  // One clock of the model, using inputs seen at the edge and its own state.
  task automatic model_update();
    bit idle_now = !exp_busy();
    bit fin = (m_bre.size() == 1) && bus.bin_ready_i;
    bit acc = bus.sample_valid_i && (m_held.size() < 4);
    if (m_bre.size() != 0 && bus.bin_ready_i) begin
      void'(m_bre.pop_front());
      void'(m_bim.pop_front());
    end
    if (m_wait) begin
      if (bus.fft_done_i) begin
        for (int k = 0; k < 4; k++) begin
          m_bre.push_back(bus.fft_output_real_i[k*CW +: CW]);
          m_bim.push_back(bus.fft_output_imag_i[k*CW +: CW]);
        end
        m_wait = 0;
      end else if (m_wcnt == T - 1) begin
        m_tmo = 1;
        m_wait = 0;
      end else begin
        m_wcnt++;
      end
    end
    if (m_read) begin
      m_wait = 1;
      m_wcnt = 0;
    end
    m_read = 0;
    if (acc) begin
      m_held.push_back(bus.sample_in_i);
      m_acc++;
    end
    if (m_held.size() == 4 && (idle_now || fin)) begin
      m_frame = {m_held[3], m_held[2], m_held[1], m_held[0]};
      repeat (4) void'(m_held.pop_front());
      m_read = 1;
    end
  endtask

  task automatic compare();
    chk("sample_ready", 64'(bus.sample_ready_o), 64'(m_held.size() < 4));
    chk("fft_read", 64'(bus.fft_read_o), 64'(m_read));
    chk("busy", 64'(bus.busy_o), 64'(exp_busy()));
    chk("timeout_error", 64'(bus.timeout_error_o), 64'(m_tmo));
    chk("bin_valid", 64'(bus.bin_valid_o), 64'(m_bre.size() != 0));
    if (m_bre.size() != 0) begin
      chk("bin_real", 64'(bus.bin_real_o), 64'(m_bre[0]));
      chk("bin_imag", 64'(bus.bin_imag_o), 64'(m_bim[0]));
      chk("bin_index", 64'(bus.bin_index_o), 64'(4 - m_bre.size()));
      chk("bin_last", 64'(bus.bin_last_o), 64'(m_bre.size() == 1));
    end
    if (m_read || m_wait) chk("fft_input_real", 64'(bus.fft_input_real_o), 64'(m_frame));
  endtask

  // FFT stub: fft_done stub_lat cycles after the strobe; junk data otherwise.
  task automatic stub_step();
    bit fire = 0;
    logic [4*CW-1:0] r, im;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0 && stub_arm) fire = 1;
    end
    for (int k = 0; k < 4; k++) begin
      r[k*CW +: CW]  = (fire && stub_fixed) ? fx_re[k] : CW'($urandom);
      im[k*CW +: CW] = (fire && stub_fixed) ? fx_im[k] : CW'($urandom);
    end
    bus.fft_output_real_i = r;
    bus.fft_output_imag_i = im;
    bus.fft_done_i = 1'b0;
    if (fire) begin
      stub_arm = 0;
      fire_cyc = cyc;
      bus.fft_done_i = 1'b1;
    end else if (spur_en && !m_read && !m_wait && $urandom_range(0, 3) == 0) begin
      bus.fft_done_i = 1'b1;
    end
    if (m_read && stub_lat > 0) begin
      stub_cnt = stub_lat;
      stub_arm = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    compare();
    if (bus.fft_read_o) n_reads++;
    stub_step();
  endtask

  task automatic send_samples(int n, logic [SW-1:0] base, bit rnd);
    int start = m_acc;
    int guard = 0;
    while (m_acc - start < n && guard < 500) begin
      bus.sample_valid_i = 1'b1;
      bus.sample_in_i = rnd ? SW'($urandom) : base + SW'(m_acc - start);
      tick();
      guard++;
      if (!bus.sample_ready_o && !ready_drop_seen) begin
        ready_drop_seen = 1;
        acc_at_drop = m_acc;
      end
    end
    bus.sample_valid_i = 1'b0;
    if (guard >= 500) bound_fail("send_samples");
  endtask

  task automatic wait_idle(int bound);
    int g = 0;
    while ((exp_busy() || m_held.size() == 4) && g < bound) begin
      tick();
      g++;
    end
    if (g >= bound) bound_fail("wait_idle");
  endtask

  task automatic wait_bin(int idx, int bound);
    int g = 0;
    while (!(bus.bin_valid_o && bus.bin_index_o == 2'(idx)) && g < bound) begin
      tick();
      g++;
    end
    if (g >= bound) bound_fail("wait_bin");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, k, g, acc0, rd0, vp, rp;
    fx_re[0] = 24'hF00000; fx_re[1] = 24'hF00001; fx_re[2] = 24'h7FFFFF; fx_re[3] = 24'h800000;
    fx_im[0] = 24'h000100; fx_im[1] = 24'hFFFFFF; fx_im[2] = 24'h123456; fx_im[3] = 24'hABCDEF;
    bus.sample_in_i = '0; bus.sample_valid_i = 1'b0; bus.fft_done_i = 1'b0;
    bus.fft_output_real_i = '0; bus.fft_output_imag_i = '0; bus.bin_ready_i = 1'b0;
    stub_lat = 3; stub_fixed = 0; spur_en = 0; n_reads = 0; fire_cyc = -100;
    ready_drop_seen = 0; acc_at_drop = -1; m_acc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_sample_ready", 64'(bus.sample_ready_o), 64'd1);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_bin_valid", 64'(bus.bin_valid_o), 64'd0);
    chk("rst_frame", 64'(bus.fft_input_real_o), 64'd0);
    rst_n = 1'b1;

    // 1: samples 1..4, done 3 cycles after the strobe, fixed stub bins
    stub_fixed = 1; stub_lat = 3; bus.bin_ready_i = 1'b1;
    send_samples(4, 16'd1, 0);
    chk("t1_fft_read", 64'(bus.fft_read_o), 64'd1);
    chk("t1_frame", 64'(bus.fft_input_real_o), 64'h0004_0003_0002_0001);
    rc = cyc; k = 0; g = 0;
    while (k < 4 && g < 50) begin
      tick(); g++;
      if (bus.bin_valid_o) begin
        if (k == 0) begin
          chk("t1_bin_latency", 64'(cyc - fire_cyc), 64'd1);
          chk("t1_done_after_read", 64'(fire_cyc - rc), 64'd3);
        end
        chk("t1_bin_real", 64'(bus.bin_real_o), 64'(fx_re[k]));
        chk("t1_bin_imag", 64'(bus.bin_imag_o), 64'(fx_im[k]));
        chk("t1_bin_index", 64'(bus.bin_index_o), 64'(k));
        chk("t1_bin_last", 64'(bus.bin_last_o), 64'(k == 3));
        k++;
      end
    end
    if (k < 4) bound_fail("t1_bins");
    stub_fixed = 0;
    wait_idle(20);

    // 2: backpressure for 5 cycles on bin 1
    stub_lat = 2;
    send_samples(4, 16'h8000, 0);
    wait_bin(1, 40);
    bus.bin_ready_i = 1'b0;
    repeat (5) begin
      tick();
      chk("t2_hold_index", 64'(bus.bin_index_o), 64'd1);
      chk("t2_hold_valid", 64'(bus.bin_valid_o), 64'd1);
    end
    bus.bin_ready_i = 1'b1;
    wait_idle(20);

    // 3: 12 samples streamed, 10-cycle FFT
    stub_lat = 10; ready_drop_seen = 0; acc_at_drop = -1;
    acc0 = m_acc; rd0 = n_reads;
    send_samples(12, 16'h0100, 0);
    wait_idle(200);
    chk("t3_ready_drop_after", 64'(acc_at_drop - acc0), 64'd8);
    chk("t3_frames", 64'(n_reads - rd0), 64'd3);

    // 4: no fft_done -> timeout, then a normal frame
    stub_lat = 0;
    send_samples(4, 16'h7FF0, 0);
    rc = cyc; g = 0;
    while (!bus.timeout_error_o && g < 200) begin tick(); g++; end
    chk("t4_timeout_delay", 64'(cyc - rc), 64'(T + 1));
    chk("t4_idle", 64'(bus.busy_o), 64'd0);
    chk("t4_no_bin", 64'(bus.bin_valid_o), 64'd0);
    stub_lat = 2;
    send_samples(4, 16'h0200, 0);
    wait_idle(50);
    chk("t4_sticky", 64'(bus.timeout_error_o), 64'd1);

    // 5: reset during DRAIN at bin 2 with a partial frame collected
    stub_lat = 4;
    send_samples(4, 16'h0A00, 0);
    send_samples(2, 16'h0B00, 0);
    wait_bin(2, 40);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_sample_ready", 64'(bus.sample_ready_o), 64'd1);
    chk("t5_fft_read", 64'(bus.fft_read_o), 64'd0);
    chk("t5_frame", 64'(bus.fft_input_real_o), 64'd0);
    chk("t5_bin_valid", 64'(bus.bin_valid_o), 64'd0);
    chk("t5_bin_real", 64'(bus.bin_real_o), 64'd0);
    chk("t5_bin_imag", 64'(bus.bin_imag_o), 64'd0);
    chk("t5_bin_index", 64'(bus.bin_index_o), 64'd0);
    chk("t5_bin_last", 64'(bus.bin_last_o), 64'd0);
    chk("t5_busy", 64'(bus.busy_o), 64'd0);
    chk("t5_timeout", 64'(bus.timeout_error_o), 64'd0);
    model_reset();
    bus.fft_done_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_samples(4, 16'h0C00, 0);
    chk("t5_new_frame", 64'(bus.fft_input_real_o), 64'h0C03_0C02_0C01_0C00);
    wait_idle(30);

    // 6: frame completes on the final DRAIN handshake
    stub_lat = 3;
    send_samples(4, 16'h0D00, 0);
    send_samples(3, 16'h0E00, 0);
    wait_bin(3, 40);
    bus.sample_valid_i = 1'b1;
    bus.sample_in_i = 16'h0E03;
    tick();
    bus.sample_valid_i = 1'b0;
    chk("t6_read_next", 64'(bus.fft_read_o), 64'd1);
    chk("t6_ready", 64'(bus.sample_ready_o), 64'd1);
    chk("t6_frame", 64'(bus.fft_input_real_o), 64'h0E03_0E02_0E01_0E00);
    wait_idle(30);

    // 7: randomized soak with spurious fft_done outside BUSY
    spur_en = 1; vp = 70; rp = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        vp = $urandom_range(10, 100);
        rp = $urandom_range(10, 100);
      end
      bus.sample_valid_i = ($urandom_range(0, 99) < vp);
      bus.sample_in_i = SW'($urandom);
      bus.bin_ready_i = ($urandom_range(0, 99) < rp);
      stub_lat = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 12);
      tick();
    end
    bus.sample_valid_i = 1'b0; bus.bin_ready_i = 1'b1; stub_lat = 2; spur_en = 0;
    wait_idle(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
